// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared helpers for rv valid/ready pipeline blocks
package rv_pipe_pkg;

    localparam int RV_PIPE_DEFAULT_WIDTH = 64;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rvdff_pipe_stage.sv
// rtl/rvdff_pipe_stage.sv - one valid/ready register stage with flush clear
module rvdff_pipe_stage #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             i_load,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Data only captures real payload, so bubbles and idle stages never toggle it.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_up_valid;
            if (i_up_valid) begin
                r_data <= i_up_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/rvdff_pipe.sv
// rtl/rvdff_pipe.sv - elastic DEPTH-stage valid/ready pipeline register
module rvdff_pipe
    import rv_pipe_pkg::*;
#(
    parameter int               WIDTH     = RV_PIPE_DEFAULT_WIDTH,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [CW-1:0]    w_count;

    assign w_rdy[DEPTH] = out_ready;

    // An empty stage is always ready, which lets bubbles collapse under backpressure.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        assign w_rdy[gi] = ~w_v[gi] | w_rdy[gi+1];

        if (gi == 0) begin : g_head
            rvdff_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk        (clk),
                .rst_l      (rst_l),
                .flush      (flush),
                .i_load     (w_rdy[gi]),
                .i_up_valid (in_valid),
                .i_up_data  (in_data),
                .o_valid    (w_v[gi]),
                .o_data     (w_d[gi])
            );
        end else begin : g_body
            rvdff_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk        (clk),
                .rst_l      (rst_l),
                .flush      (flush),
                .i_load     (w_rdy[gi]),
                .i_up_valid (w_v[gi-1]),
                .i_up_data  (w_d[gi-1]),
                .o_valid    (w_v[gi]),
                .o_data     (w_d[gi])
            );
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CW'(w_v[i]);
        end
    end

    assign in_ready  = w_rdy[0] & ~flush & rst_l;
    assign out_valid = w_v[DEPTH-1] & ~flush;
    assign out_data  = w_d[DEPTH-1];
    assign count     = w_count;

endmodule

// File: tb/tb_rvdff_pipe.sv
// tb/tb_rvdff_pipe.sv - directed and scoreboarded checks of rvdff_pipe
module tb_rvdff_pipe;

    logic        clk;
    logic        rst_l;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [1:0]  count;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data, a_out_data;
    logic [0:0]  a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_count;

    int n_cmp = 0;
    int n_err = 0;

    rvdff_pipe #(.WIDTH(64), .DEPTH(3), .RESET_VAL(64'hDEAD_BEEF)) u_dut (
        .clk(clk), .rst_l(rst_l), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    rvdff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) u_d1 (
        .clk(clk), .rst_l(rst_l), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    rvdff_pipe #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'hC3)) u_d5 (
        .clk(clk), .rst_l(rst_l), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] qm[$];
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    bit          drain, m_hold, a_hold, b_hold;

    initial begin
        rst_l = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        m_hold = 1'b0; a_hold = 1'b0; b_hold = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_in_ready_low", in_ready, 0);
        rst_l = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 64'hDEAD_BEEF);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_d1_data", a_out_data, 8'h5A);
        chk("rst_d5_data", b_out_data, 8'hC3);

        // DEPTH=1 boundary: full single stage, then pass-through with out_ready
        a_in_valid = 1'b1; a_in_data = 8'h11;
        tick();
        chk("d1_valid", a_out_valid, 1);
        chk("d1_data", a_out_data, 8'h11);
        chk("d1_count", a_count, 1);
        chk("d1_full_stall", a_in_ready, 0);
        a_out_ready = 1'b1; a_in_data = 8'h22;
        #1;
        chk("d1_ready_thru", a_in_ready, 1);
        tick();
        chk("d1_data2", a_out_data, 8'h22);
        chk("d1_count2", a_count, 1);
        a_in_valid = 1'b0;
        tick();
        chk("d1_empty", a_out_valid, 0);
        chk("d1_count0", a_count, 0);
        a_out_ready = 1'b0;

        // Streaming
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h1;
        tick(); chk("st_v1", out_valid, 0); chk("st_c1", count, 1);
        in_data = 64'h2;
        tick(); chk("st_v2", out_valid, 0); chk("st_c2", count, 2);
        in_data = 64'h3;
        tick(); chk("st_v3", out_valid, 1); chk("st_d3", out_data, 64'h1); chk("st_c3", count, 3);
        in_data = 64'h4;
        tick(); chk("st_d4", out_data, 64'h2); chk("st_c4", count, 3);
        in_valid = 1'b0;
        tick(); chk("st_d5", out_data, 64'h3); chk("st_c5", count, 2);
        tick(); chk("st_d6", out_data, 64'h4); chk("st_c6", count, 1);
        tick(); chk("st_v7", out_valid, 0); chk("st_c7", count, 0);

        // Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hA; tick();
        in_data = 64'hB; tick();
        in_data = 64'hC; tick();
        in_data = 64'hD;
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_count", count, 3);
        chk("bp_head", out_data, 64'hA);
        tick();
        chk("bp_hold_count", count, 3);
        chk("bp_hold_head", out_data, 64'hA);
        out_ready = 1'b1;
        #1;
        chk("bp_full_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        chk("bp_o_b", out_data, 64'hB); chk("bp_full_cnt", count, 3);
        tick(); chk("bp_o_c", out_data, 64'hC);
        tick(); chk("bp_o_d", out_data, 64'hD); chk("bp_o_dv", out_valid, 1);
        tick(); chk("bp_empty", out_valid, 0); chk("bp_c0", count, 0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h55; tick();
        in_valid = 1'b0; tick(); tick();
        chk("bc_count1", count, 1);
        chk("bc_last", out_data, 64'h55);
        in_valid = 1'b1; in_data = 64'h66;
        #1; chk("bc_rdy1", in_ready, 1);
        tick();
        in_data = 64'h77;
        #1; chk("bc_rdy2", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bc_count3", count, 3);
        out_ready = 1'b1;
        #1; chk("bc_o1", out_data, 64'h55);
        tick(); chk("bc_o2", out_data, 64'h66);
        tick(); chk("bc_o3", out_data, 64'h77);
        tick(); chk("bc_empty", out_valid, 0);

        // Flush
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hE1; tick();
        in_data = 64'hE2; tick();
        in_data = 64'hE3; tick();
        in_data = 64'hF0; flush = 1'b1;
        #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_count", count, 0);
        chk("fl_out_valid2", out_valid, 0);
        chk("fl_data_kept", out_data, 64'hE1);
        chk("fl_in_ready2", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("fl_accept", count, 1);
        out_ready = 1'b1;
        tick(); tick();
        chk("fl_o_v", out_valid, 1);
        chk("fl_o_d", out_data, 64'hF0);
        tick(); chk("fl_drained", count, 0);

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h101; tick();
        in_data = 64'h102; tick();
        in_data = 64'h103; tick();
        in_valid = 1'b0;
        chk("rm_full", count, 3);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        #1;
        chk("rm_count", count, 0);
        chk("rm_out_valid", out_valid, 0);
        chk("rm_out_data", out_data, 64'hDEAD_BEEF);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rm_no_stale", out_valid, 0);
        end

        // Random stalls against reference queues, DEPTH 1/3/5
        for (int c = 0; c < 300; c++) begin
            drain = (c >= 280);
            if (!m_hold) begin
                in_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
                in_data  = {$urandom, $urandom};
            end
            if (!a_hold) begin
                a_in_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
                a_in_data  = 8'($urandom);
            end
            if (!b_hold) begin
                b_in_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
                b_in_data  = 8'($urandom);
            end
            out_ready   = drain ? 1'b1 : 1'($urandom_range(0, 1));
            a_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
            b_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk("rnd_count_d3", count, qm.size());
            chk("rnd_count_d1", a_count, qa.size());
            chk("rnd_count_d5", b_count, qb.size());
            if (out_valid && out_ready) begin
                if (qm.size() == 0) chk("rnd_extra_d3", 1, 0);
                else chk("rnd_data_d3", out_data, qm.pop_front());
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("rnd_extra_d1", 1, 0);
                else chk("rnd_data_d1", a_out_data, qa.pop_front());
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("rnd_extra_d5", 1, 0);
                else chk("rnd_data_d5", b_out_data, qb.pop_front());
            end
            if (in_valid && in_ready) qm.push_back(in_data);
            if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
            if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
            m_hold = in_valid && !in_ready;
            a_hold = a_in_valid && !a_in_ready;
            b_hold = b_in_valid && !b_in_ready;
            tick();
        end
        chk("rnd_drain_d3", qm.size(), 0);
        chk("rnd_drain_d1", qa.size(), 0);
        chk("rnd_drain_d5", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
